// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default register-address width and operand-mux select encodings.
package pipe_pkg;

  localparam int REG_ADDR_W_DFLT = 2;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

endpackage

// File: rtl/fwd_sel_calc.sv
// Per-operand comparator: derives the forwarding select and the hazard flag for one ID source register.
// FWD_HAZARD_FORWARD_EN selects forwarding; without it every in-flight producer becomes a stall.
module fwd_sel_calc
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  vld_p1,
  input  logic [REG_ADDR_W-1:0] rd_p1,
  input  logic                  we_p1,
  input  logic                  ld_p1,
  input  logic                  vld_p2,
  input  logic [REG_ADDR_W-1:0] rd_p2,
  input  logic                  we_p2,
  output logic [1:0]            sel,
  output logic                  hazard
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = vld_p1 & we_p1 & (rd_p1 == rs);
  assign mem_hit = vld_p2 & we_p2 & (rd_p2 == rs);

`ifdef FWD_HAZARD_FORWARD_EN
  // EX is checked first so the youngest producer wins; a load in EX has no data yet.
  always_comb begin
    sel = SEL_RF;
    if (ex_hit && !ld_p1) begin
      sel = SEL_EXMEM;
    end else if (mem_hit) begin
      sel = SEL_MEMWB;
    end
  end

  assign hazard = ex_hit & ld_p1;
`else
  logic unused_ld;

  assign unused_ld = ld_p1;
  assign sel       = SEL_RF;
  assign hazard    = ex_hit | mem_hit;
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard unit tracking the EX and MEM stage records of a 5-stage pipeline.
// Build macro FWD_HAZARD_FORWARD_EN enables operand forwarding; otherwise hazards are resolved by stalling.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_a,
  input  logic [REG_ADDR_W-1:0] id_rs_b,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [1:0]            sel_a,
  output logic [1:0]            sel_b,
  output logic                  stall
);

  logic                  vld_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic                  we_p1;
  logic                  ld_p1;
  logic                  vld_p2;
  logic [REG_ADDR_W-1:0] rd_p2;
  logic                  we_p2;

  logic [1:0] sel_a_p0;
  logic [1:0] sel_b_p0;
  logic       hazard_a;
  logic       hazard_b;
  logic       advance;

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_calc_a (
    .rs     (id_rs_a),
    .vld_p1 (vld_p1),
    .rd_p1  (rd_p1),
    .we_p1  (we_p1),
    .ld_p1  (ld_p1),
    .vld_p2 (vld_p2),
    .rd_p2  (rd_p2),
    .we_p2  (we_p2),
    .sel    (sel_a_p0),
    .hazard (hazard_a)
  );

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_calc_b (
    .rs     (id_rs_b),
    .vld_p1 (vld_p1),
    .rd_p1  (rd_p1),
    .we_p1  (we_p1),
    .ld_p1  (ld_p1),
    .vld_p2 (vld_p2),
    .rd_p2  (rd_p2),
    .we_p2  (we_p2),
    .sel    (sel_b_p0),
    .hazard (hazard_b)
  );

  // A flush squashes the ID instruction, so it can neither stall nor enter EX.
  assign stall   = id_valid & ~flush & (hazard_a | hazard_b);
  assign advance = id_valid & ~flush & ~stall;

  // ID -> EX (p1) -> MEM (p2): valid bits and selects are reset, stage payload is not.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      sel_a  <= SEL_RF;
      sel_b  <= SEL_RF;
    end else begin
      vld_p2 <= vld_p1;
      vld_p1 <= advance;
      sel_a  <= advance ? sel_a_p0 : SEL_RF;
      sel_b  <= advance ? sel_b_p0 : SEL_RF;
    end
  end

  always_ff @(posedge clock) begin
    rd_p2 <= rd_p1;
    we_p2 <= we_p1;
    rd_p1 <= id_rd;
    we_p1 <= id_wr_en;
    ld_p1 <= id_is_load;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed hazard sequences plus randomized traffic and reset pulses.
module tb_fwd_hazard_unit;
  import pipe_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  logic       id_valid;
  logic [1:0] id_rs_a;
  logic [1:0] id_rs_b;
  logic [1:0] id_rd;
  logic       id_wr_en;
  logic       id_is_load;
  logic       flush;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       stall;

  always #5 clock = ~clock;

  fwd_hazard_unit #(.REG_ADDR_W(2)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .id_valid   (id_valid),
    .id_rs_a    (id_rs_a),
    .id_rs_b    (id_rs_b),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .flush      (flush),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .stall      (stall)
  );

  typedef struct packed {
    logic        st;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [31:0] seq;
  } exp_t;

  typedef struct {
    bit       v;
    bit [1:0] rd;
    bit       we;
    bit       ld;
  } instr_t;

  exp_t   exp_q[$];
  instr_t flight[2];   // [0] = instruction in EX, [1] = instruction in MEM
  bit [1:0] m_sel_a;
  bit [1:0] m_sel_b;
  int unsigned seq = 0;
  int errors = 0;
  int checks = 0;

  // Youngest in-flight producer of rs: 0 none, 1 ALU in EX, 2 load in EX, 3 anything in MEM.
  function automatic int producer(input bit [1:0] rs);
    for (int i = 0; i < 2; i++) begin
      if (flight[i].v && flight[i].we && flight[i].rd == rs) begin
        if (i == 0) return flight[i].ld ? 2 : 1;
        return 3;
      end
    end
    return 0;
  endfunction

  function automatic bit [1:0] fwd_code(input int p);
    if (p == 1) return 2'b01;
    if (p == 3) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input bit v, input bit [1:0] a, input bit [1:0] b, input bit [1:0] d,
                      input bit we, input bit ld, input bit fl, output bit st);
    int       pa;
    int       pb;
    bit [1:0] na;
    bit [1:0] nb;
    bit       enter;
    @(negedge clock);
    resetn = 1'b1; id_valid = v; id_rs_a = a; id_rs_b = b; id_rd = d;
    id_wr_en = we; id_is_load = ld; flush = fl;
    pa = producer(a);
    pb = producer(b);
`ifdef FWD_HAZARD_FORWARD_EN
    st = v && !fl && (pa == 2 || pb == 2);
    na = fwd_code(pa);
    nb = fwd_code(pb);
`else
    st = v && !fl && (pa != 0 || pb != 0);
    na = 2'b00;
    nb = 2'b00;
`endif
    exp_q.push_back('{st: st, sa: m_sel_a, sb: m_sel_b, seq: seq});
    seq++;
    enter = v && !fl && !st;
    flight[1] = flight[0];
    if (enter) flight[0] = '{v: 1'b1, rd: d, we: we, ld: ld};
    else       flight[0] = '{v: 1'b0, rd: 2'b00, we: 1'b0, ld: 1'b0};
    m_sel_a = enter ? na : 2'b00;
    m_sel_b = enter ? nb : 2'b00;
  endtask

  task automatic rst_cycle();
    @(negedge clock);
    resetn = 1'b0;
    id_valid = 1'b1; id_rs_a = 2'($urandom_range(3)); id_rs_b = 2'($urandom_range(3));
    id_rd = 2'($urandom_range(3)); id_wr_en = 1'b1; id_is_load = 1'($urandom_range(1));
    flush = 1'b0;
    flight[0] = '{v: 1'b0, rd: 2'b00, we: 1'b0, ld: 1'b0};
    flight[1] = '{v: 1'b0, rd: 2'b00, we: 1'b0, ld: 1'b0};
    m_sel_a = 2'b00;
    m_sel_b = 2'b00;
    exp_q.push_back('{st: 1'b0, sa: 2'b00, sb: 2'b00, seq: seq});
    seq++;
  endtask

  // Re-present the instruction while the unit holds IF/ID.
  task automatic issue(input bit [1:0] a, input bit [1:0] b, input bit [1:0] d,
                       input bit we, input bit ld);
    bit st;
    int g;
    g = 0;
    step(1'b1, a, b, d, we, ld, 1'b0, st);
    while (st && g < 4) begin
      step(1'b1, a, b, d, we, ld, 1'b0, st);
      g++;
    end
  endtask

  task automatic nop();
    bit st;
    step(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, st);
  endtask

  task automatic chk(input string name, input int unsigned sq, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at item %0d: got %0d, expected %0d", name, sq, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare one cycle after the stimulus edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", e.seq, int'(stall), int'(e.st));
        chk("sel_a", e.seq, int'(sel_a), int'(e.sa));
        chk("sel_b", e.seq, int'(sel_b), int'(e.sb));
      end
    end
  end

  initial begin
    bit       st;
    bit       v;
    bit       we;
    bit       ld;
    bit       fl;
    bit [1:0] ra;
    bit [1:0] rb;
    bit [1:0] rd;
    resetn = 1'b0; id_valid = 1'b0; id_rs_a = 2'd0; id_rs_b = 2'd0; id_rd = 2'd0;
    id_wr_en = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) rst_cycle();

    // ADD r1 ; ADD r2,r1,r3
    issue(2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
    issue(2'd1, 2'd3, 2'd2, 1'b1, 1'b0);
    nop(); nop();
    // writer r1 ; independent ; reader of r1 on rs_b
    issue(2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
    issue(2'd2, 2'd3, 2'd0, 1'b0, 1'b0);
    issue(2'd0, 2'd1, 2'd2, 1'b1, 1'b0);
    nop(); nop();
    // LOAD r2 ; reader of r2
    issue(2'd0, 2'd0, 2'd2, 1'b1, 1'b1);
    issue(2'd2, 2'd0, 2'd1, 1'b1, 1'b0);
    nop(); nop();
    // two writers of r3 ; reader of r3
    issue(2'd0, 2'd0, 2'd3, 1'b1, 1'b0);
    issue(2'd1, 2'd1, 2'd3, 1'b1, 1'b0);
    issue(2'd3, 2'd3, 2'd0, 1'b1, 1'b0);
    nop(); nop();
    // load-use with flush in the same cycle
    issue(2'd0, 2'd0, 2'd2, 1'b1, 1'b1);
    step(1'b1, 2'd2, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, st);
    nop(); nop();
    // reset pulse mid-stream, then a reader of the pre-reset writer
    issue(2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
    rst_cycle(); rst_cycle();
    issue(2'd1, 2'd1, 2'd0, 1'b1, 1'b0);
    nop();

    st = 1'b0;
    v = 1'b0; we = 1'b0; ld = 1'b0; ra = 2'd0; rb = 2'd0; rd = 2'd0;
    for (int i = 0; i < 800; i++) begin
      if (!st) begin
        v  = $urandom_range(3) != 0;
        ra = 2'($urandom_range(3));
        rb = 2'($urandom_range(3));
        rd = 2'($urandom_range(3));
        we = $urandom_range(3) != 0;
        ld = $urandom_range(2) == 0;
      end
      fl = $urandom_range(7) == 0;
      if ($urandom_range(59) == 0) begin
        rst_cycle();
        st = 1'b0;
      end else begin
        step(v, ra, rb, rd, we, ld, fl, st);
      end
    end

    @(negedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 2, register-address width (4 architectural registers).
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port id_valid  input  1  a real instruction sits in ID this cycle.
REQ-005 SHALL have ports id_rs_a and id_rs_b  input  REG_ADDR_W  source registers of the ID instruction.
REQ-006 SHALL have port id_rd  input  REG_ADDR_W  destination register of the ID instruction.
REQ-007 SHALL have ports id_wr_en and id_is_load  input  1  the ID instruction writes id_rd, and it is a load.
REQ-008 SHALL have port flush  input  1  squash the ID instruction (taken branch).
REQ-009 SHALL have ports sel_a and sel_b  output  2  registered operand-mux selects for the instruction now in EX.
REQ-010 SHALL have port stall  output  1  combinational; hold PC and IF/ID, insert a bubble into EX.

Function
REQ-011 SHALL track two internal stage records, EX {v, rd, we, ld} and MEM {v, rd, we}, mirroring the datapath pipeline registers.
REQ-012 SHALL advance every clock: MEM <= EX; EX <= ID fields when id_valid & !stall & !flush, else a bubble (v=0).
REQ-013 SHALL treat a stage as a writer only when v=1 and we=1.
REQ-014 SHALL encode selects as 00 register file, 01 EX/MEM ALU result, 10 MEM/WB result; 11 never driven.
REQ-015 SHALL compute each select for the ID instruction and register it on the edge that moves it into EX: 01 if EX is a non-load writer with rd==rs; else 10 if MEM is a writer with rd==rs; else 00.
REQ-016 SHALL give priority to EX over MEM when both match (newest value wins).
REQ-017 SHALL assert stall when id_valid & !flush and EX is a load writer with rd equal to id_rs_a or id_rs_b.
REQ-018 SHALL register sel_a/sel_b as 00 on any cycle where the instruction does not enter EX (stall, flush, !id_valid).
REQ-019 SHALL rely on the register file's write-through: a WB-stage writer needs no forwarding.
REQ-020 SHALL make flush dominate stall: stall=0 and EX <= bubble in a flush cycle.
REQ-021 SHALL, after a load-use stall, forward the load data next cycle through select 10 (load now in MEM), with exactly one stall cycle.

Reset
REQ-022 SHALL, while resetn=0, clear EX.v and MEM.v, drive sel_a=sel_b=00, and drive stall=0.
REQ-023 SHALL treat reset deasserted mid-sequence as an empty pipeline: no forwarding or stall is derived from pre-reset instructions.

Configuration
REQ-024 SHALL honour macro FWD_HAZARD_FORWARD_EN: when defined, behave as in REQ-015..REQ-021.
REQ-025 SHALL, with FWD_HAZARD_FORWARD_EN undefined, drive sel_a=sel_b=00 permanently and assert stall whenever EX or MEM is a writer whose rd matches a valid ID source; this costs up to 2 stall cycles.

Structure
REQ-026 SHALL take REG_ADDR_W's default and the select encodings (SEL_RF, SEL_EXMEM, SEL_MEMWB) from a shared package, pipe_pkg.
REQ-027 SHALL be implemented as a single module; the per-operand comparator is a natural sub-module, fwd_sel_calc, instanced twice.

Verification
REQ-028 SHALL cover: ADD r1 then ADD r2,r1,r3 back-to-back -> consumer in EX with sel_a=01, stall never asserted.
REQ-029 SHALL cover: writer r1, independent instruction, then reader of r1 on rs_b -> sel_b=10.
REQ-030 SHALL cover: LOAD r2, then reader of r2 -> stall=1 for exactly one cycle; then sel=10.
REQ-031 SHALL cover: EX and MEM both write r3, ID reads r3 -> sel=01.
REQ-032 SHALL cover: load-use hazard with flush in the same cycle -> stall=0, next sel=00, EX bubble; resetn pulsed low mid-stream -> sel=00, stall=0 immediately.
REQ-033 SHALL cover: build without FWD_HAZARD_FORWARD_EN, ADD r1 then reader of r1 -> stall for 2 cycles, sel always 00.
